// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, instruction format enum and the
// registered decode bundle. Also holds the legality check used by imm_gen and the top.
package decode_pkg;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   // Everything except pc and imm, whose widths are parameters of the stage.
   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [6:0] funct7;
      fmt_e       fmt;
      logic       illegal;
   } dec_t;

   function automatic logic is_legal(input logic [31:0] instr);
      if (instr[1:0] != 2'b11) return 1'b0;
      case (instr[6:0])
         OP_OP, OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM,
         OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational format select and sign-extended immediate build.
// Illegal encodings decode as R-format with a zero immediate.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output fmt_e            fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      fmt   = FMT_R;
      imm32 = '0;
      if (is_legal(instr)) begin
         case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: fmt = FMT_I;
            OP_STORE:                                      fmt = FMT_S;
            OP_BRANCH:                                     fmt = FMT_B;
            OP_LUI, OP_AUIPC:                              fmt = FMT_U;
            OP_JAL:                                        fmt = FMT_J;
            default:                                       fmt = FMT_R;
         endcase
      end
      case (fmt)
         FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm32 = {instr[31:12], 12'b0};
         FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // imm32 is already sign-correct at bit 31, so widening just replicates it.
   generate
      if (XLEN > 32) begin : g_wide
         assign imm = {{(XLEN-32){imm32[31]}}, imm32};
      end else begin : g_narrow
         assign imm = imm32;
      end
   endgenerate

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: main register plus one skid register, registered in_ready.
// Define DECODE_ILLEGAL_EN to report illegal encodings and zero their rd.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_funct3,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   fmt_e            dec_fmt;
   logic [XLEN-1:0] dec_imm;
   dec_t            dec;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (in_instr),
      .fmt   (dec_fmt),
      .imm   (dec_imm)
   );

   always_comb begin
      dec.opcode = in_instr[6:0];
      dec.funct3 = in_instr[14:12];
      dec.rs1    = in_instr[19:15];
      dec.rs2    = in_instr[24:20];
      dec.funct7 = in_instr[31:25];
      dec.fmt    = dec_fmt;
`ifdef DECODE_ILLEGAL_EN
      dec.illegal = !is_legal(in_instr);
      dec.rd      = dec.illegal ? 5'd0 : in_instr[11:7];
`else
      dec.illegal = 1'b0;
      dec.rd      = in_instr[11:7];
`endif
   end

   logic            main_vld, skid_vld, rdy_q;
   dec_t            main_d, skid_d;
   logic [PC_W-1:0] main_pc, skid_pc;
   logic [XLEN-1:0] main_imm, skid_imm;

   logic in_xfer, main_free, main_load_skid, main_load_in, skid_load;

   // Skid is only ever filled while in_ready is high, so an input transfer
   // never coincides with a skid-to-main move.
   assign in_xfer        = in_valid & rdy_q;
   assign main_free      = !main_vld | out_ready;
   assign main_load_skid = main_free & skid_vld;
   assign main_load_in   = main_free & !skid_vld & in_xfer;
   assign skid_load      = !main_free & in_xfer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         rdy_q    <= 1'b0;
      end else if (flush) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         main_vld <= main_free ? (skid_vld | in_xfer) : 1'b1;
         skid_vld <= !main_free & (skid_vld | in_xfer);
         rdy_q    <= main_free | !(skid_vld | in_xfer);
      end
   end

   // Payload carries no reset; it is qualified by the valid bits above.
   always_ff @(posedge clk) begin
      if (main_load_skid) begin
         main_d   <= skid_d;
         main_pc  <= skid_pc;
         main_imm <= skid_imm;
      end else if (main_load_in) begin
         main_d   <= dec;
         main_pc  <= in_pc;
         main_imm <= dec_imm;
      end
      if (skid_load) begin
         skid_d   <= dec;
         skid_pc  <= in_pc;
         skid_imm <= dec_imm;
      end
   end

   assign in_ready    = rdy_q;
   assign out_valid   = main_vld;
   assign out_pc      = main_pc;
   assign out_opcode  = main_d.opcode;
   assign out_rd      = main_d.rd;
   assign out_funct3  = main_d.funct3;
   assign out_rs1     = main_d.rs1;
   assign out_rs2     = main_d.rs2;
   assign out_funct7  = main_d.funct7;
   assign out_imm     = main_imm;
   assign out_fmt     = main_d.fmt;
   assign out_illegal = main_d.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field/immediate decode, skid backpressure,
// flush and mid-stream reset. A second XLEN=64 instance checks immediate widening.
module tb_decode_stage;
   import decode_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;

   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_pc, out_imm;
   logic [6:0]  out_opcode, out_funct7;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [2:0]  out_funct3, out_fmt;

   logic        w_in_ready, w_out_valid, w_out_illegal;
   logic [31:0] w_out_pc;
   logic [63:0] w_out_imm;
   logic [6:0]  w_out_opcode, w_out_funct7;
   logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
   logic [2:0]  w_out_funct3, w_out_fmt;

`ifdef DECODE_ILLEGAL_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   decode_stage #(.XLEN(32), .PC_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
      .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
   );

   decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc),
      .out_opcode(w_out_opcode), .out_rd(w_out_rd), .out_funct3(w_out_funct3),
      .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_funct7(w_out_funct7),
      .out_imm(w_out_imm), .out_fmt(w_out_fmt), .out_illegal(w_out_illegal)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      int          sent, got, cyc, k;
      logic        saw_block, held;
      logic [31:0] held_pc;

      // reset state
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      step();
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_hold_ready", in_ready, 0);
      step();
      chk("rst_release_ready", in_ready, 1);
      chk("rst_release_valid", out_valid, 0);

      // addi x1,x2,-1
      send(32'hFFF10093, 32'h100);
      chk("addi_valid", out_valid, 1);
      chk("addi_pc", out_pc, 32'h100);
      chk("addi_rd", out_rd, 1);
      chk("addi_rs1", out_rs1, 2);
      chk("addi_fmt", out_fmt, FMT_I);
      chk("addi_imm", out_imm, 32'hFFFFFFFF);
      chk("addi_imm64", w_out_imm, 64'hFFFFFFFFFFFFFFFF);
      chk("addi_ill", out_illegal, 0);
      chk("addi_ready", in_ready, 1);

      // sw x5,8(x2)
      send(32'h00512423, 32'h104);
      chk("sw_fmt", out_fmt, FMT_S);
      chk("sw_rs1", out_rs1, 2);
      chk("sw_rs2", out_rs2, 5);
      chk("sw_f3", out_funct3, 2);
      chk("sw_imm", out_imm, 32'h00000008);

      // lui x1,0x12345
      send(32'h123450B7, 32'h108);
      chk("lui_fmt", out_fmt, FMT_U);
      chk("lui_rd", out_rd, 1);
      chk("lui_imm", out_imm, 32'h12345000);
      chk("lui_imm64", w_out_imm, 64'h0000000012345000);

      // beq x0,x0,-4
      send(32'hFE000EE3, 32'h10C);
      chk("beq_fmt", out_fmt, FMT_B);
      chk("beq_f7", out_funct7, 7'h7F);
      chk("beq_imm", out_imm, 32'hFFFFFFFC);
      chk("beq_imm64", w_out_imm, 64'hFFFFFFFFFFFFFFFC);

      // jal x1,8
      send(32'h008000EF, 32'h110);
      chk("jal_fmt", out_fmt, FMT_J);
      chk("jal_rd", out_rd, 1);
      chk("jal_imm", out_imm, 32'h00000008);

      // add x3,x1,x2
      send(32'h002081B3, 32'h114);
      chk("add_fmt", out_fmt, FMT_R);
      chk("add_rd", out_rd, 3);
      chk("add_rs2", out_rs2, 2);
      chk("add_imm", out_imm, 0);

      // all-zero word: low bits not 11
      send(32'h00000000, 32'h118);
      chk("zero_fmt", out_fmt, FMT_R);
      chk("zero_imm", out_imm, 0);
      chk("zero_ill", out_illegal, ILL_EN);
      chk("zero_rd", out_rd, 0);

      // unlisted opcode 1111111 with rd=1 and non-zero upper bits
      send(32'hFFF000FF, 32'h11C);
      chk("unl_fmt", out_fmt, FMT_R);
      chk("unl_imm", out_imm, 0);
      chk("unl_ill", out_illegal, ILL_EN);
      chk("unl_rd", out_rd, ILL_EN ? 5'd0 : 5'd1);

      step();
      chk("drain_valid", out_valid, 0);

      // back-to-back stream of addi x(k),x0,k with a 3-cycle stall
      sent = 0; got = 0; cyc = 0; saw_block = 1'b0; held = 1'b0; held_pc = '0;
      while (got < 6 && cyc < 40) begin
         out_ready = !(cyc >= 2 && cyc < 5);
         k         = sent + 1;
         in_valid  = (sent < 6);
         in_instr  = (k << 20) | (k << 7) | 32'h13;
         in_pc     = 32'h1000 + 4 * k;
         if (held) chk("stall_stable_pc", out_pc, held_pc);
         if (!in_ready) saw_block = 1'b1;
         if (out_valid && out_ready) begin
            got++;
            chk("ord_pc", out_pc, 32'h1000 + 4 * got);
            chk("ord_rd", out_rd, got);
            chk("ord_imm", out_imm, got);
         end
         held    = out_valid && !out_ready;
         held_pc = out_pc;
         if (in_valid && in_ready) sent++;
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_count", got, 6);
      chk("stream_sent", sent, 6);
      chk("stream_in_ready_fell", saw_block, 1);
      chk("stream_no_dup", out_valid, 0);

      // fill main and skid, then flush
      out_ready = 1'b0;
      send(32'h00100093, 32'h200);
      send(32'h00200113, 32'h204);
      chk("full_ready", in_ready, 0);
      chk("full_valid", out_valid, 1);
      chk("full_pc", out_pc, 32'h200);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_valid", out_valid, 0);
      chk("flush_ready", in_ready, 1);

      // flush wins over a same-cycle input transfer
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h00300193;
      in_pc    = 32'h208;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_ovr_valid", out_valid, 0);
      step();
      chk("flush_ovr_valid2", out_valid, 0);

      // reset pulse with an instruction held
      send(32'h00100093, 32'h300);
      chk("prerst_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_ready", in_ready, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      chk("postrst_ready", in_ready, 1);
      chk("postrst_valid", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
